// File: rtl/block_sorter_stream.sv
// block_sorter_stream
//   Collects N-element blocks from an input stream, keeps each partial block
//   sorted as elements arrive (one-cycle parallel insertion), and hands each
//   completed block to an output buffer that drains one element per transfer.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data is one element
//   out_valid/out_ready : output handshake, out_data is one sorted element
//   out_last            : out_data is the final element of its block
module block_sorter_stream #(
  parameter int DW      = 8,
  parameter int N       = 4,
  parameter int SIGNED  = 0,
  parameter int DESCEND = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last
);
  localparam int FW = $clog2(N);

  logic [N-1:0][DW-1:0] s_q, s_d, o_q, o_d, ins;
  logic [FW-1:0]        fill_q, fill_d, idx_q, idx_d, idx_nx;
  logic                 occ_q, occ_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [N-1:0]         gb;
  logic                 full_blk, in_xfer, out_xfer, last_xfer, blk_done;

  // True when a strictly precedes b in output order. Strictness keeps the
  // sort stable: a new element lands behind every existing equal element.
  function automatic logic goes_before(logic [DW-1:0] a, logic [DW-1:0] b);
    logic lt, gt;
    if (SIGNED != 0) begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end else begin
      lt = a < b;
      gt = a > b;
    end
    return (DESCEND != 0) ? gt : lt;
  endfunction

  assign full_blk  = (fill_q == FW'(N-1));
  assign out_xfer  = occ_q && out_ready;
  assign last_xfer = out_xfer && out_last_q;
  assign in_ready  = rst_n && !(full_blk && occ_q && !last_xfer);
  assign in_xfer   = in_valid && in_ready;
  assign blk_done  = in_xfer && full_blk;
  assign idx_nx    = idx_q + FW'(1);

  assign out_valid = occ_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

  // Parallel insertion. gb[i] marks slots the new element belongs in front
  // of; empty slots count as "in front" so the element lands at fill when it
  // precedes nothing. Because S is sorted, gb is 0...0 1...1, and the first
  // set bit is the insertion point; everything after it shifts up one.
  always_comb begin
    for (int i = 0; i < N; i++)
      gb[i] = (i >= int'(fill_q)) || goes_before(in_data, s_q[i]);
    ins[0] = gb[0] ? in_data : s_q[0];
    for (int i = 1; i < N; i++) begin
      if (!gb[i])          ins[i] = s_q[i];
      else if (!gb[i-1])   ins[i] = in_data;
      else                 ins[i] = s_q[i-1];
    end
  end

  always_comb begin
    s_d        = s_q;
    fill_d     = fill_q;
    o_d        = o_q;
    occ_d      = occ_q;
    idx_d      = idx_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;

    if (in_xfer) begin
      s_d    = ins;
      fill_d = full_blk ? '0 : fill_q + FW'(1);
    end

    if (out_xfer) begin
      if (out_last_q) begin
        occ_d      = 1'b0;
        idx_d      = '0;
        out_last_d = 1'b0;
      end else begin
        idx_d      = idx_nx;
        out_data_d = o_q[idx_nx];
        out_last_d = (idx_nx == FW'(N-1));
      end
    end

    // A completing block can only coincide with an empty buffer or with the
    // out_last transfer, so it overrides the drain update above.
    if (blk_done) begin
      o_d        = ins;
      occ_d      = 1'b1;
      idx_d      = '0;
      out_data_d = ins[0];
      out_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q        <= '0;
      fill_q     <= '0;
      o_q        <= '0;
      occ_q      <= 1'b0;
      idx_q      <= '0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      fill_q     <= fill_d;
      o_q        <= o_d;
      occ_q      <= occ_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end
endmodule

// File: tb/tb_block_sorter_stream.sv
// Drives three sorter variants (unsigned ascending, signed ascending,
// unsigned descending) with one shared stream; all three accept and emit in
// lockstep, only the order inside each block differs.
module tb_block_sorter_stream;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready;
  logic [7:0] in_data;
  logic [2:0] ir, ov, ol;
  logic [7:0] od [3];

  always #5 clk = ~clk;

  block_sorter_stream #(.DW(8), .N(N), .SIGNED(0), .DESCEND(0)) u_uns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]));
  block_sorter_stream #(.DW(8), .N(N), .SIGNED(1), .DESCEND(0)) u_sgn (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]));
  block_sorter_stream #(.DW(8), .N(N), .SIGNED(0), .DESCEND(1)) u_dsc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .out_last(ol[2]));

  int checks = 0;
  int errors = 0;
  int pend[$];                    // accepted elements of the open block
  int exp0[$], exp1[$], exp2[$];  // per-variant expected output order
  bit orv = 1'b1;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int key(input int inst, input int x);
    case (inst)
      1:       return (x >= 128) ? x - 256 : x;
      2:       return -x;
      default: return x;
    endcase
  endfunction

  // Stable sort by rank: position = number of elements with a smaller key,
  // plus earlier arrivals with an equal key.
  task automatic complete_block();
    int srt [3][N];
    for (int m = 0; m < 3; m++)
      for (int j = 0; j < N; j++) begin
        int r = 0;
        for (int k = 0; k < N; k++)
          if (key(m, pend[k]) < key(m, pend[j]) ||
              (key(m, pend[k]) == key(m, pend[j]) && k < j)) r++;
        srt[m][r] = pend[j];
      end
    for (int j = 0; j < N; j++) begin
      exp0.push_back(srt[0][j]);
      exp1.push_back(srt[1][j]);
      exp2.push_back(srt[2][j]);
    end
    pend.delete();
  endtask

  task automatic cycle(input bit v, input int d, output bit acc);
    int sz;
    bit exp_ir;
    int e;
    in_valid  = v;
    in_data   = 8'(d);
    out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : orv;
    #1;
    sz     = exp0.size();
    exp_ir = !(pend.size() == N-1 && sz > 0 && !(out_ready && sz == 1));
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", 32'(ir[i]), 32'(exp_ir));
      chk("out_valid", 32'(ov[i]), 32'(sz > 0));
      if (sz > 0) begin
        e = (i == 0) ? exp0[0] : (i == 1) ? exp1[0] : exp2[0];
        chk("out_data", 32'(od[i]), 32'(e));
        chk("out_last", 32'(ol[i]), 32'(sz == 1));
      end
    end
    if (out_ready && sz > 0) begin
      void'(exp0.pop_front());
      void'(exp1.pop_front());
      void'(exp2.pop_front());
    end
    acc = v && exp_ir;
    if (acc) begin
      pend.push_back(d);
      if (pend.size() == N) complete_block();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int d);
    bit acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) cycle(1'b1, d, acc);
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted data=%0d", d);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int t = 0; t < n; t++) cycle(1'b0, 0, acc);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) chk("in_ready_in_reset", 32'(ir[i]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pend.delete();
    exp0.delete();
    exp1.delete();
    exp2.delete();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_valid", 32'(ov[i]), 32'd0);
      chk("rst_out_last", 32'(ol[i]), 32'd0);
      chk("rst_out_data", 32'(od[i]), 32'd0);
      chk("rst_in_ready", 32'(ir[i]), 32'd1);
    end
  endtask

  initial begin
    bit acc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    do_reset();

    // basic block, then signed/unsigned contrast, then descending with ties
    send(5); send(3); send(9); send(1);
    idle(6);
    send(8'h80); send(8'h7F); send(8'h00); send(8'hFF);
    idle(6);
    send(4); send(7); send(4); send(2);
    idle(6);

    // backpressure: 80 must wait for the out_last edge of the first block
    orv = 1'b0;
    for (int v = 10; v <= 70; v += 10) send(v);
    cycle(1'b1, 80, acc);
    checks++;
    assert (!acc) else begin
      errors++;
      $error("FAIL stall_80 observed=accepted expected=stalled");
    end
    orv = 1'b1;
    send(80);
    idle(6);

    // reset mid-block and mid-drain
    send(200); send(100);
    do_reset();
    send(4); send(3); send(2); send(1);
    idle(6);
    orv = 1'b0;
    send(11); send(22); send(33); send(44);
    orv = 1'b1;
    idle(2);
    do_reset();
    idle(3);

    // random stream with random consumer backpressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 64; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      if (n % 2 == 0) send(int'($urandom_range(0, 255)));
      else            send(int'($urandom_range(0, 7)));
    end
    rnd_rdy = 1'b0;
    orv     = 1'b1;
    idle(10);
    chk("drained", 32'(pend.size() + exp0.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
